// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell and one carry flop, LSB first,
// with a valid/ready handshake on both the operand and the result sides.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic s_bit;
    logic c_next;

    assign s_bit  = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
    assign c_next = (a_sh_q[0] & b_sh_q[0]) | (carry_q & (a_sh_q[0] ^ b_sh_q[0]));

    always_comb begin
        // NOTE: every next-state signal takes its hold value first, so no path leaves one unassigned (no latches).
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = cin;
                    sum_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
                sum_d   = {s_bit, sum_q[WIDTH-1:1]};
                carry_d = c_next;
                // The counter stops at its last value rather than wrapping on the final bit.
                if (cnt_q == LAST) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign sum       = sum_q;
    assign cout      = carry_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: an 8-bit and a 2-bit instance share
// the clock and reset; use2 selects which one is driven and observed.
module tb_serial_adder;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       out_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       use2;

    logic       in_ready8, out_valid8, cout8, busy8;
    logic [7:0] sum8;
    logic       in_ready2, out_valid2, cout2, busy2;
    logic [1:0] sum2;

    logic       obs_in_ready, obs_out_valid, obs_cout, obs_busy;
    logic [7:0] obs_sum;

    int         errors;
    int         checks;
    logic [8:0] exp_q[$];

    serial_adder #(.WIDTH(8)) dut8 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid & ~use2),
        .in_ready (in_ready8),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .out_valid(out_valid8),
        .out_ready(out_ready & ~use2),
        .sum      (sum8),
        .cout     (cout8),
        .busy     (busy8)
    );

    serial_adder #(.WIDTH(2)) dut2 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid & use2),
        .in_ready (in_ready2),
        .a        (a[1:0]),
        .b        (b[1:0]),
        .cin      (cin),
        .out_valid(out_valid2),
        .out_ready(out_ready & use2),
        .sum      (sum2),
        .cout     (cout2),
        .busy     (busy2)
    );

    assign obs_in_ready  = use2 ? in_ready2  : in_ready8;
    assign obs_out_valid = use2 ? out_valid2 : out_valid8;
    assign obs_cout      = use2 ? cout2      : cout8;
    assign obs_busy      = use2 ? busy2      : busy8;
    assign obs_sum       = use2 ? {6'b0, sum2} : sum8;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One full transaction: push the expected result, present the operands,
    // time the latency, hold off the result for 'hold' cycles, then hand it off.
    task automatic run_op(input logic [7:0] oa, input logic [7:0] ob, input logic oc,
                          input int hold, input bit scramble);
        logic [8:0] exp;
        logic [2:0] s2;
        logic [7:0] held_sum;
        logic       held_cout;
        int         n;
        int         w;
        w = use2 ? 2 : 8;
        if (use2) begin
            s2  = {1'b0, oa[1:0]} + {1'b0, ob[1:0]} + {2'b0, oc};
            exp = {s2[2], 6'b0, s2[1:0]};
        end else begin
            exp = {1'b0, oa} + {1'b0, ob} + {8'b0, oc};
        end
        exp_q.push_back(exp);

        n = 0;
        while (!obs_in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("in_ready_idle", obs_in_ready, 1);

        a = oa; b = ob; cin = oc; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;

        n = 0;
        while (!obs_out_valid && n < 40) begin
            check("busy_run", obs_busy, 1);
            if (scramble) begin
                a        = 8'($urandom);
                b        = 8'($urandom);
                cin      = 1'($urandom);
                in_valid = 1'($urandom);
            end
            @(posedge clk); #1;
            n++;
        end
        check("latency", n, w);
        check("result", {obs_cout, obs_sum}, exp_q.pop_front());

        held_sum  = obs_sum;
        held_cout = obs_cout;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            a        = 8'($urandom);
            b        = 8'($urandom);
            cin      = 1'($urandom);
            @(posedge clk); #1;
            check("hold_valid", obs_out_valid, 1);
            check("hold_sum", obs_sum, held_sum);
            check("hold_cout", obs_cout, held_cout);
            check("hold_no_accept", obs_in_ready, 0);
            check("hold_busy", obs_busy, 1);
        end

        // Output handshake with in_valid also high: only the handshake may happen.
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("handoff_idle", obs_in_ready, 1);
        check("handoff_valid", obs_out_valid, 0);
        check("handoff_busy", obs_busy, 0);
        check("retain_sum", {obs_cout, obs_sum}, {held_cout, held_sum});
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        use2      = 1'b0;
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;

        // Reset asserted mid-cycle must take effect with no clock edge.
        repeat (2) @(posedge clk);
        #1; #3;
        rst = 1'b1;
        #1;
        check("rst_out_valid", out_valid8, 0);
        check("rst_sum", sum8, 0);
        check("rst_cout", cout8, 0);
        check("rst_busy", busy8, 0);
        check("rst_in_ready", in_ready8, 1);
        @(posedge clk); #1;
        check("rst_hold_in_ready", in_ready8, 1);
        rst = 1'b0;

        // First edge after reset release accepts.
        run_op(8'h35, 8'h4A, 1'b0, 0, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0, 0, 1'b0);
        run_op(8'hFF, 8'hFF, 1'b1, 0, 1'b0);
        run_op(8'h00, 8'h00, 1'b1, 0, 1'b0);

        // Backpressure, then the next operands go in right after.
        run_op(8'h12, 8'h34, 1'b0, 5, 1'b0);
        run_op(8'hC3, 8'h5A, 1'b1, 0, 1'b0);

        // Abort a run after three bit-cycles.
        a = 8'hAA; b = 8'h55; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("pre_abort_busy", busy8, 1);
        #2;
        rst = 1'b1;
        #1;
        check("abort_out_valid", out_valid8, 0);
        check("abort_sum", sum8, 0);
        check("abort_cout", cout8, 0);
        check("abort_busy", busy8, 0);
        check("abort_in_ready", in_ready8, 1);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("abort_never_presented", out_valid8, 0);
        run_op(8'h10, 8'h20, 1'b0, 0, 1'b0);

        // Operand isolation: inputs scrambled every cycle while running.
        run_op(8'h9C, 8'h77, 1'b1, 0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            run_op(8'($urandom), 8'($urandom), 1'($urandom), i, 1'b1);
        end

        // Narrowest legal width.
        use2 = 1'b1;
        run_op(8'h03, 8'h03, 1'b1, 0, 1'b1);
        run_op(8'h02, 8'h01, 1'b0, 2, 1'b1);
        run_op(8'h01, 8'h01, 1'b0, 0, 1'b0);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and sum width in bits; legal range is 2..32.
REQ-002 Port clk SHALL be an input, 1 bit wide: the single clock; all state updates occur on its rising edge.
REQ-003 Port rst SHALL be an input, 1 bit wide: the reset, asynchronous and active-high.
REQ-004 Port in_valid SHALL be an input, 1 bit wide: the operand set is valid.
REQ-005 Port in_ready SHALL be an output, 1 bit wide: the block can accept an operand set.
REQ-006 Port a SHALL be an input, WIDTH bits wide: operand A.
REQ-007 Port b SHALL be an input, WIDTH bits wide: operand B.
REQ-008 Port cin SHALL be an input, 1 bit wide: the carry-in.
REQ-009 Port out_valid SHALL be an output, 1 bit wide: sum and cout are valid.
REQ-010 Port out_ready SHALL be an input, 1 bit wide: the consumer accepts the result.
REQ-011 Port sum SHALL be an output, WIDTH bits wide: the result, a+b+cin modulo 2^WIDTH.
REQ-012 Port cout SHALL be an output, 1 bit wide: the carry-out of the addition.
REQ-013 Port busy SHALL be an output, 1 bit wide: high whenever state is not IDLE.

Function
REQ-014 The block SHALL compute one result bit per clock, LSB first, using one half-adder/half-adder full-adder cell and one carry flip-flop.
REQ-015 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-016 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-017 IDLE: on an edge with in_valid=1, the block SHALL load a and b into shift registers, load cin into the carry register, clear the bit counter and the sum shift register, and enter RUN.
REQ-018 RUN, each edge: bit s SHALL equal a_sh[0]^b_sh[0]^c, and c SHALL become a_sh[0]&b_sh[0] | c&(a_sh[0]^b_sh[0]).
REQ-019 RUN, each edge: a_sh and b_sh SHALL shift right, s SHALL shift into the sum register MSB, and the counter SHALL increment.
REQ-020 RUN: on the edge where the counter equals WIDTH-1, the block SHALL perform the last bit and enter DONE.
REQ-021 Latency: if an operand set is accepted on edge k, out_valid SHALL be high immediately after edge k+WIDTH, with no pipelining and no variation.
REQ-022 DONE: sum SHALL present the sum register and cout SHALL present the carry register; both SHALL be held stable while out_valid=1 and out_ready=0.
REQ-023 DONE: on an edge with out_ready=1, the block SHALL enter IDLE; sum and cout SHALL retain their last values until the next acceptance.
REQ-024 a, b, cin and in_valid SHALL be ignored in RUN and DONE; operand changes mid-operation SHALL NOT affect the result.
REQ-025 If in_valid=1 and out_ready=1 on the same edge in DONE, only the output handshake SHALL occur; the earliest input acceptance is the next edge, from IDLE, giving a throughput of at most one result per WIDTH+2 cycles.
REQ-026 The counter SHALL be $clog2(WIDTH) bits wide, SHALL NOT wrap inside RUN, and SHALL be cleared on each acceptance.
REQ-027 cout SHALL be the final carry; there SHALL be no overflow flag beyond cout.

Reset
REQ-028 While rst=1, regardless of the clock, the block SHALL force state=IDLE, with the counter, shift registers, sum, cout, carry, out_valid and busy all at 0.
REQ-029 in_ready SHALL be 1 during and after reset.
REQ-030 Reset asserted in RUN or DONE SHALL abort the operation; the partial result SHALL be discarded and never presented.
REQ-031 After rst deasserts, the first rising edge SHALL be able to accept an operand set.

Verification
REQ-032 Reset: assert rst mid-cycle with no clock edge -> out_valid=0, sum=0, cout=0, busy=0, in_ready=1 immediately.
REQ-033 Basic add, WIDTH=8: a=8'h35, b=8'h4A, cin=0 accepted on edge k -> sum=8'h7F, cout=0, with out_valid first high after edge k+8 and busy high for cycles k+1..k+8 and through DONE.
REQ-034 Carry chain: a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1; then a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1; then a=0, b=0, cin=1 -> sum=8'h01, cout=0.
REQ-035 Backpressure: out_ready=0 for 5 cycles in DONE while in_valid=1 with new operands -> out_valid, sum and cout held constant and no acceptance; out_ready=1 -> IDLE next edge, new operands accepted on the following edge, and their result correct.
REQ-036 Abort: pulse rst after 3 RUN cycles of a=8'hAA, b=8'h55 -> all outputs 0 and state IDLE at once; a new add of 8'h10+8'h20 -> sum=8'h30, cout=0, exactly 8 cycles after acceptance.
REQ-037 Operand isolation: change a and b every cycle during RUN -> result equals the sum of the operands latched at acceptance; repeat with WIDTH=2, a=2'b11, b=2'b11, cin=1 -> sum=2'b11, cout=1.
